// File: rtl/road_fighter_pkg.sv
// Shared types and constants for the road-fighter car pipeline.
// Contents:
//   MASK_VALUE    - transparent pixel color produced by the car drawers
//   car_state_t   - packed AI car state, indexed with IMG/X/Y/W/H
//   crash_state_t - crash sequence states
//   is_opaque()   - true when a pixel color is not the transparent value
package road_fighter_pkg;

  localparam logic [7:0] MASK_VALUE = 8'h62;

  // Field indices into car_state_t
  localparam int IMG = 0;
  localparam int X   = 1;
  localparam int Y   = 2;
  localparam int W   = 3;
  localparam int H   = 4;

  typedef logic [4:0][10:0] car_state_t;

  typedef enum logic [1:0] {
    DRIVING = 2'd0,
    CRASH   = 2'd1,
    RECOVER = 2'd2
  } crash_state_t;

  function automatic logic is_opaque(input logic [7:0] color);
    return color != MASK_VALUE;
  endfunction

endpackage

// File: rtl/pixel_overlap_detector.sv
// Per-pixel overlap detection between the player car and the AI cars.
// Ports:
//   clk, resetN   - clock, asynchronous active-low reset
//   frame_start   - one-cycle pulse at the start of a frame
//   pixel_valid   - the colors on this cycle belong to a visible pixel
//   player_color  - player car pixel (MASK_VALUE = transparent)
//   ai_color      - NUM_AI AI car pixels (MASK_VALUE = transparent)
//   hit_pending   - at least one overlap seen so far in the current frame
//   hit_id        - lowest-index AI car of the first overlap of the frame
module pixel_overlap_detector
  import road_fighter_pkg::*;
#(
  parameter int NUM_AI = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [7:0]             player_color,
  input  logic [NUM_AI-1:0][7:0] ai_color,
  output logic                   hit_pending,
  output logic [2:0]             hit_id
);

  logic [NUM_AI-1:0] ai_opaque;
  logic              hit;
  logic [2:0]        hit_idx;

  generate
    for (genvar gi = 0; gi < NUM_AI; gi++) begin : g_mask
      assign ai_opaque[gi] = is_opaque(ai_color[gi]);
    end
  endgenerate

  assign hit = pixel_valid && is_opaque(player_color) && (|ai_opaque);

  // Scan from the top down so the lowest opaque index wins.
  always_comb begin
    hit_idx = 3'd0;
    for (int i = NUM_AI - 1; i >= 0; i--) begin
      if (ai_opaque[i]) hit_idx = 3'(i);
    end
  end

  // A hit coinciding with frame_start belongs to the new frame, so the
  // clear and the new latch happen on the same edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_pending <= 1'b0;
      hit_id      <= 3'd0;
    end else if (frame_start) begin
      hit_pending <= hit;
      if (hit) hit_id <= hit_idx;
    end else if (hit && !hit_pending) begin
      hit_pending <= 1'b1;
      hit_id      <= hit_idx;
    end
  end

endmodule

// File: rtl/car_crash_monitor.sv
// Crash monitor: turns per-frame player/AI overlaps into a crash sequence
// (spin at zero speed, then a linear speed-limit ramp back to full speed).
// NUM_AI must be 1..8 since car ids are carried on 3 bits.
// Ports:
//   clk, resetN   - clock, asynchronous active-low reset
//   frame_start   - one-cycle pulse at the start of a frame
//   pixel_valid   - colors on this cycle belong to a visible pixel
//   player_color  - player car pixel (8'h62 = transparent)
//   ai_color      - NUM_AI AI car pixels (8'h62 = transparent)
//   ai_car_state  - NUM_AI packed car states {IMG,X,Y,W,H}
//   crash         - one-cycle pulse when a crash is accepted
//   crash_active  - high while in CRASH or RECOVER
//   crash_car_id  - AI car index of the last accepted crash
//   crash_x       - x field of that car captured at acceptance
//   speed_limit   - maximum allowed player speed
//   crash_count   - accepted crashes, saturating at 255
module car_crash_monitor
  import road_fighter_pkg::*;
#(
  parameter int         NUM_AI      = 4,
  parameter int         SPIN_FRAMES = 60,
  parameter int         RAMP_STEP   = 32,
  parameter logic [9:0] MAX_SPEED   = 10'd640
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [7:0]             player_color,
  input  logic [NUM_AI-1:0][7:0] ai_color,
  input  car_state_t [NUM_AI-1:0] ai_car_state,
  output logic                   crash,
  output logic                   crash_active,
  output logic [2:0]             crash_car_id,
  output logic [10:0]            crash_x,
  output logic [9:0]             speed_limit,
  output logic [7:0]             crash_count
);

  localparam int SPIN_W = (SPIN_FRAMES > 1) ? $clog2(SPIN_FRAMES) : 1;

  crash_state_t      state, state_next;
  logic [SPIN_W-1:0] spin_cnt, spin_cnt_next;
  logic              crash_next;
  logic              crash_active_next;
  logic [2:0]        crash_car_id_next;
  logic [10:0]       crash_x_next;
  logic [9:0]        speed_limit_next;
  logic [7:0]        crash_count_next;

  logic              hit_pending;
  logic [2:0]        hit_id;
  logic [10:0]       hit_x;
  logic [10:0]       ramp_sum;
  logic              unused_state_bits;

  pixel_overlap_detector #(
    .NUM_AI(NUM_AI)
  ) u_detector (
    .clk         (clk),
    .resetN      (resetN),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .player_color(player_color),
    .ai_color    (ai_color),
    .hit_pending (hit_pending),
    .hit_id      (hit_id)
  );

  // Only the x field is consumed here.
  assign unused_state_bits = ^ai_car_state;

  // Select x of the hitting car without indexing past NUM_AI-1.
  always_comb begin
    hit_x = 11'd0;
    for (int i = 0; i < NUM_AI; i++) begin
      if (hit_id == 3'(i)) hit_x = ai_car_state[i][X];
    end
  end

  // 11-bit sum so the ramp can never wrap below MAX_SPEED.
  assign ramp_sum = {1'b0, speed_limit} + 11'(RAMP_STEP);

  always_comb begin
    state_next        = state;
    spin_cnt_next     = spin_cnt;
    crash_next        = 1'b0;
    crash_car_id_next = crash_car_id;
    crash_x_next      = crash_x;
    speed_limit_next  = speed_limit;
    crash_count_next  = crash_count;

    if (frame_start) begin
      case (state)
        DRIVING: begin
          if (hit_pending) begin
            state_next        = CRASH;
            crash_next        = 1'b1;
            crash_car_id_next = hit_id;
            crash_x_next      = hit_x;
            if (crash_count != 8'hff) crash_count_next = crash_count + 8'd1;
            spin_cnt_next     = SPIN_W'(SPIN_FRAMES - 1);
            speed_limit_next  = 10'd0;
          end else begin
            speed_limit_next  = MAX_SPEED;
          end
        end
        CRASH: begin
          if (spin_cnt == '0) begin
            state_next       = RECOVER;
            speed_limit_next = 10'(RAMP_STEP);
          end else begin
            spin_cnt_next    = spin_cnt - 1'b1;
            speed_limit_next = 10'd0;
          end
        end
        RECOVER: begin
          if (ramp_sum >= {1'b0, MAX_SPEED}) begin
            speed_limit_next = MAX_SPEED;
            state_next       = DRIVING;
          end else begin
            speed_limit_next = ramp_sum[9:0];
          end
        end
        default: begin
          state_next       = DRIVING;
          speed_limit_next = MAX_SPEED;
        end
      endcase
    end

    crash_active_next = (state_next != DRIVING);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= DRIVING;
      spin_cnt     <= '0;
      crash        <= 1'b0;
      crash_active <= 1'b0;
      crash_car_id <= 3'd0;
      crash_x      <= 11'd0;
      speed_limit  <= MAX_SPEED;
      crash_count  <= 8'd0;
    end else begin
      state        <= state_next;
      spin_cnt     <= spin_cnt_next;
      crash        <= crash_next;
      crash_active <= crash_active_next;
      crash_car_id <= crash_car_id_next;
      crash_x      <= crash_x_next;
      speed_limit  <= speed_limit_next;
      crash_count  <= crash_count_next;
    end
  end

endmodule

// File: tb/tb_car_crash_monitor.sv
// Directed bench for car_crash_monitor: a table of single-frame overlap
// vectors plus hand-written sequences for the spin/ramp timeline,
// frame_start-coincident hits, mid-crash reset and count saturation.
module tb_car_crash_monitor;
  import road_fighter_pkg::*;

  logic              clk = 1'b0;
  logic              resetN;
  logic              frame_start;
  logic              pixel_valid;
  logic [7:0]        player_color;
  logic [3:0][7:0]   ai_color;
  car_state_t [3:0]  ai_car_state;
  logic              crash;
  logic              crash_active;
  logic [2:0]        crash_car_id;
  logic [10:0]       crash_x;
  logic [9:0]        speed_limit;
  logic [7:0]        crash_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  car_crash_monitor #(
    .NUM_AI(4), .SPIN_FRAMES(60), .RAMP_STEP(32), .MAX_SPEED(10'd640)
  ) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .player_color(player_color),
    .ai_color(ai_color), .ai_car_state(ai_car_state),
    .crash(crash), .crash_active(crash_active), .crash_car_id(crash_car_id),
    .crash_x(crash_x), .speed_limit(speed_limit), .crash_count(crash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [7:0]  player;
    logic [31:0] ai_a;     // colors on the first pixel cycle
    logic [31:0] ai_b;     // colors on the second pixel cycle
    logic        exp_crash;
    int          exp_id;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_edge();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clear_px();
    pixel_valid  = 1'b0;
    player_color = 8'h62;
    ai_color     = {4{8'h62}};
  endtask

  task automatic overlap(input int car);
    pixel_valid   = 1'b1;
    player_color  = 8'hf8;
    ai_color      = {4{8'h62}};
    ai_color[car] = 8'h00;
  endtask

  task automatic idle_frames(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      frame_edge();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_crash"}, crash, 0);
    check({tag, "_active"}, crash_active, 0);
    check({tag, "_id"}, crash_car_id, 0);
    check({tag, "_x"}, crash_x, 0);
    check({tag, "_speed"}, speed_limit, 640);
    check({tag, "_count"}, crash_count, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hf8, 32'h62006262, 32'h62626262, 1'b1, 2};
    vecs[1] = '{1'b1, 8'hf8, 32'h00626262, 32'h62620062, 1'b1, 3};
    vecs[2] = '{1'b0, 8'hf8, 32'h62626200, 32'h62626262, 1'b0, 0};
    vecs[3] = '{1'b1, 8'h62, 32'h62620062, 32'h62626262, 1'b0, 0};
    vecs[4] = '{1'b1, 8'hf8, 32'h62000062, 32'h62626262, 1'b1, 1};
    vecs[5] = '{1'b1, 8'hf8, 32'h62626262, 32'h62626262, 1'b0, 0};
    vecs[6] = '{1'b1, 8'hf8, 32'h62626262, 32'h62626200, 1'b1, 0};

    for (int i = 0; i < 4; i++) begin
      ai_car_state[i]    = '0;
      ai_car_state[i][X] = 11'(100 + 40 * i);
      ai_car_state[i][Y] = 11'(20 * i);
    end

    clear_px();
    frame_start = 1'b0;
    resetN = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    resetN = 1'b1;
    tick();

    // Three empty frames: nothing happens
    for (int f = 0; f < 3; f++) begin
      tick();
      frame_edge();
      check("idle_crash", crash, 0);
      check("idle_speed", speed_limit, 640);
      check("idle_active", crash_active, 0);
      check("idle_count", crash_count, 0);
    end

    // Table-driven single-frame vectors
    for (int v = 0; v < 7; v++) begin
      clear_px();
      frame_edge();
      pixel_valid  = vecs[v].pv;
      player_color = vecs[v].player;
      ai_color     = vecs[v].ai_a;
      tick();
      ai_color     = vecs[v].ai_b;
      tick();
      clear_px();
      tick();
      frame_edge();
      $display("vec %0d: crash=%0d id=%0d x=%0d speed=%0d count=%0d",
               v, crash, crash_car_id, crash_x, speed_limit, crash_count);
      check("vec_crash", crash, int'(vecs[v].exp_crash));
      if (vecs[v].exp_crash) begin
        exp_count++;
        check("vec_id", crash_car_id, vecs[v].exp_id);
        check("vec_x", crash_x, 100 + 40 * vecs[v].exp_id);
        check("vec_speed", speed_limit, 0);
        check("vec_active", crash_active, 1);
      end
      check("vec_count", crash_count, exp_count);
      tick();
      check("vec_pulse_end", crash, 0);
      if (vecs[v].exp_crash) begin
        idle_frames(79);
        check("vec_recovered_active", crash_active, 0);
        check("vec_recovered_speed", speed_limit, 640);
      end
    end

    // Spin and ramp timeline with overlaps injected every frame
    overlap(1);
    tick();
    clear_px();
    frame_edge();
    exp_count++;
    check("seq_crash", crash, 1);
    check("seq_id", crash_car_id, 1);
    for (int k = 1; k <= 79; k++) begin
      overlap(3);
      tick();
      clear_px();
      frame_edge();
      check("ramp_speed", speed_limit, (k < 60) ? 0 : 32 * (k - 59));
      check("ramp_crash", crash, 0);
      check("ramp_active", crash_active, (k < 79) ? 1 : 0);
      check("ramp_count", crash_count, exp_count);
    end
    $display("ramp done: speed=%0d active=%0d count=%0d", speed_limit, crash_active, crash_count);
    tick();
    frame_edge();
    check("post_ramp_crash", crash, 0);

    // Hit on the frame_start cycle belongs to the new frame
    overlap(2);
    frame_edge();
    clear_px();
    check("fs_hit_not_now", crash, 0);
    tick();
    frame_edge();
    exp_count++;
    $display("fs hit: crash=%0d id=%0d x=%0d", crash, crash_car_id, crash_x);
    check("fs_hit_next", crash, 1);
    check("fs_hit_id", crash_car_id, 2);
    check("fs_hit_x", crash_x, 180);
    check("fs_hit_count", crash_count, exp_count);
    idle_frames(79);

    // Reset while spinning with spin_cnt at 30
    overlap(0);
    tick();
    clear_px();
    frame_edge();
    check("midreset_crash", crash, 1);
    idle_frames(29);
    check("midreset_spinning", crash_active, 1);
    #2;
    resetN = 1'b0;
    #1;
    $display("mid-crash reset: active=%0d speed=%0d count=%0d", crash_active, speed_limit, crash_count);
    check_reset_values("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    tick();
    frame_edge();
    check("after_reset_crash", crash, 0);
    check("after_reset_active", crash_active, 0);

    // Saturation: continuous overlap forces back-to-back crashes
    exp_count = 0;
    overlap(0);
    for (int n = 1; n <= 256; n++) begin
      int got;
      got = 0;
      for (int f = 0; f < 100 && got == 0; f++) begin
        frame_edge();
        if (crash === 1'b1) got = 1;
        else tick();
      end
      if (exp_count < 255) exp_count++;
      check("sat_accept", got, 1);
      check("sat_count", crash_count, exp_count);
      tick();
    end
    $display("saturation: count=%0d", crash_count);
    clear_px();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
